// File: rtl/countones_pkg.sv
// Shared types and width helpers for the population-count arbiter and its datapath.
package countones_pkg;

    typedef enum logic [0:0] {
        eEmpty = 1'b0,
        eFull  = 1'b1
    } state_e;

    // Count needs one extra bit so an all-ones word fits exactly.
    function automatic int count_width(input int width);
        return $clog2(width) + 1;
    endfunction

    function automatic int id_width(input int els);
        return (els < 2) ? 1 : $clog2(els);
    endfunction

endpackage

// File: rtl/countones.sv
// Combinational population count of a width_p-bit word.
module countones
    import countones_pkg::*;
#(
    parameter int width_p = 32
) (
    input  logic [width_p-1:0]                  i,
    output logic [count_width(width_p)-1:0]     o
);

    localparam int CountW = count_width(width_p);

    always_comb begin
        o = '0;
        for (int b = 0; b < width_p; b++) begin
            o = o + CountW'(i[b]);
        end
    end

endmodule

// File: rtl/countones_arbiter.sv
// Round-robin shares one countones datapath among els_p requesters; results
// land in a single-entry register drained by a valid/yumi handshake.
module countones_arbiter
    import countones_pkg::*;
#(
    parameter int width_p = 32,
    parameter int els_p   = 4
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic [els_p-1:0]                   v_i,
    input  logic [els_p*width_p-1:0]           data_i,
    output logic [els_p-1:0]                   ready_o,
    output logic                               v_o,
    output logic [count_width(width_p)-1:0]    count_o,
    output logic [id_width(els_p)-1:0]         id_o,
    input  logic                               yumi_i
);

    localparam int CountW = count_width(width_p);
    localparam int IdW    = id_width(els_p);

    state_e              state_q, state_d;
    logic [IdW-1:0]      ptr_q, ptr_d;
    logic [CountW-1:0]   count_q, count_d;
    logic [IdW-1:0]      id_q, id_d;

    logic [els_p-1:0]    grant;
    logic [IdW-1:0]      grant_id;
    logic                accept_en;
    logic                accept;
    logic [width_p-1:0]  masked_word [els_p];
    logic [width_p-1:0]  granted_word;
    logic [CountW-1:0]   granted_count;

    // Search starts at the pointer and wraps, so the last winner goes to the back.
    always_comb begin
        int             pos;
        logic [IdW-1:0] idx;
        logic           found;
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        pos      = 0;
        idx      = '0;
        for (int i = 0; i < els_p; i++) begin
            pos = int'(ptr_q) + i;
            if (pos >= els_p) begin
                pos = pos - els_p;
            end
            idx = IdW'(pos);
            if (!found && v_i[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                grant_id    = idx;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < els_p; gi++) begin : g_mask
            assign masked_word[gi] = data_i[gi*width_p +: width_p] & {width_p{grant[gi]}};
        end
    endgenerate

    always_comb begin
        granted_word = '0;
        for (int k = 0; k < els_p; k++) begin
            granted_word = granted_word | masked_word[k];
        end
    end

    countones #(
        .width_p (width_p)
    ) u_countones (
        .i (granted_word),
        .o (granted_count)
    );

    // Draining and refilling in the same cycle keeps full throughput.
    assign accept_en = (state_q == eEmpty) || ((state_q == eFull) && yumi_i);
    assign ready_o   = reset_i ? '0 : (grant & {els_p{accept_en}});
    assign accept    = |ready_o;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        id_d    = id_q;
        if (accept) begin
            state_d = eFull;
            count_d = granted_count;
            id_d    = grant_id;
            if (int'(grant_id) == els_p - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_id + IdW'(1);
            end
        end else if ((state_q == eFull) && yumi_i) begin
            state_d = eEmpty;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= eEmpty;
            ptr_q   <= '0;
            count_q <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            id_q    <= id_d;
        end
    end

    assign v_o     = (state_q == eFull);
    assign count_o = count_q;
    assign id_o    = id_q;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert ($onehot0(ready_o));
            assert (!(yumi_i && !v_o));
            if (v_o) begin
                assert (count_o <= CountW'(width_p));
            end
        end
    end

endmodule
